// File: rtl/ioctl_pkg.sv
// Shared types and sizing helpers for the ioctl wide-word writer.
package ioctl_pkg;

  // Byte address width of the data_io download port.
  localparam int IOCTL_ADDR_W = 25;

  // Default word geometry. The sizes below are used when the writer is not overridden.
  localparam int DEF_DW = 16;
  localparam int DEF_AW = 24;

  // Byte-packing accumulator state.
  typedef enum logic {
    ACC_EMPTY   = 1'b0,
    ACC_PARTIAL = 1'b1
  } acc_state_e;

  // Number of byte lanes in a DW-bit word.
  function automatic int lanes_of(input int dw);
    return dw / 8;
  endfunction

  // Lane index width. A single-lane word has no lane bits.
  function automatic int lane_w_of(input int dw);
    return (dw / 8 > 1) ? $clog2(dw / 8) : 0;
  endfunction

  // Width of one FIFO entry {addr, data, be}.
  function automatic int fw_of(input int aw, input int dw);
    return aw + dw + dw / 8;
  endfunction

  localparam int LANES  = lanes_of(DEF_DW);
  localparam int LANE_W = lane_w_of(DEF_DW);
  localparam int FW     = fw_of(DEF_AW, DEF_DW);

  // FIFO entry record for the default geometry. The writer declares the same layout
  // for its own DW/AW.
  typedef struct packed {
    logic [DEF_AW-1:0] addr;
    logic [DEF_DW-1:0] data;
    logic [LANES-1:0]  be;
  } entry_t;

endpackage

// File: rtl/ioctl_fifo.sv
// Synchronous show-ahead FIFO. The head entry is readable combinationally while
// empty=0. Push and pop may both happen in the same cycle, including when full.
module ioctl_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  // The storage is small. It is read asynchronously so that a word pushed into an
  // empty FIFO is visible at the head on the very next cycle.
  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr_reg;
  logic [PW:0]  rd_ptr_reg;
  logic         push_ok;
  logic         pop_ok;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                   (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr_reg[PW-1:0]];

  // Write the storage array. The array is not reset, so it maps onto plain RAM.
  always_ff @(posedge clk_sys) begin
    if (push_ok) begin
      mem[wr_ptr_reg[PW-1:0]] <= din;
    end
  end

  // Advance the pointers. The extra MSB distinguishes the full state from the empty state.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ioctl_wide_writer.sv
// Packs the ioctl byte stream into DW-bit words with byte enables. The words are
// queued in a FIFO and drained to a memory port over a req/ack handshake.
module ioctl_wide_writer
  import ioctl_pkg::*;
#(
  parameter int         DW          = 16,
  parameter int         AW          = 24,
  parameter int         DEPTH       = 16,
  parameter bit         BIG_ENDIAN  = 1'b0,
  parameter logic [7:0] INDEX_MASK  = 8'h00,
  parameter logic [7:0] INDEX_MATCH = 8'h00
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    ioctl_download,
  input  logic [7:0]              ioctl_index,
  input  logic                    ioctl_wr,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]              ioctl_dout,
  output logic                    mem_req,
  input  logic                    mem_ack,
  output logic [AW-1:0]           mem_addr,
  output logic [DW-1:0]           mem_din,
  output logic [DW/8-1:0]         mem_be,
  output logic                    busy,
  output logic                    overflow,
  output logic                    done,
  output logic [AW-1:0]           word_count
);

  localparam int NLANES = lanes_of(DW);
  localparam int LW     = lane_w_of(DW);
  localparam int LIW    = (LW > 0) ? LW : 1;
  localparam int EW     = fw_of(AW, DW);

  typedef struct packed {
    logic [AW-1:0]     addr;
    logic [DW-1:0]     data;
    logic [NLANES-1:0] be;
  } word_entry_t;

  acc_state_e        state_reg, state_next;
  logic [AW-1:0]     acc_addr_reg, acc_addr_next;
  logic [DW-1:0]     acc_data_reg, acc_data_next;
  logic [NLANES-1:0] acc_be_reg, acc_be_next;
  logic              dl_prev_reg;
  logic              overflow_reg;
  logic              done_pending_reg;
  logic [AW-1:0]     word_count_reg;

  logic              accept, dl_rise, dl_fall, cur_partial, last_lane;
  logic [LIW-1:0]    lane;
  logic [AW-1:0]     word_addr;
  logic [NLANES-1:0] lane_hit;
  logic [DW-1:0]     fresh_data, merged_data;
  logic [NLANES-1:0] merged_be;
  logic              push, push_ok, pop;
  word_entry_t       push_entry, head_entry;
  logic              fifo_full, fifo_empty;
  logic [EW-1:0]     fifo_head;

  assign accept    = ioctl_wr && ioctl_download &&
                     ((ioctl_index & INDEX_MASK) == INDEX_MATCH);
  assign dl_rise   = ioctl_download && !dl_prev_reg;
  assign dl_fall   = !ioctl_download && dl_prev_reg;
  assign word_addr = AW'(ioctl_addr >> LW);
  // A download restart throws away whatever partial word was left over.
  assign cur_partial = (state_reg == ACC_PARTIAL) && !dl_rise;
  assign last_lane   = (lane == LIW'(NLANES - 1));

  generate
    if (LW == 0) begin : g_lane_single
      assign lane = '0;
    end else begin : g_lane_multi
      assign lane = ioctl_addr[LW-1:0];
    end
    // Each physical byte position gi holds logical lane LOGICAL. The byte enables
    // follow the physical position, so they line up with the data.
    for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
      localparam int LOGICAL = BIG_ENDIAN ? (NLANES - 1 - gi) : gi;
      assign lane_hit[gi]           = (lane == LIW'(LOGICAL));
      assign fresh_data[gi*8 +: 8]  = lane_hit[gi] ? ioctl_dout : 8'h00;
      assign merged_data[gi*8 +: 8] = lane_hit[gi] ? ioctl_dout :
                                      (cur_partial ? acc_data_reg[gi*8 +: 8] : 8'h00);
      assign merged_be[gi]          = lane_hit[gi] | (cur_partial & acc_be_reg[gi]);
    end
  endgenerate

  // State register for the accumulator.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_reg    <= ACC_EMPTY;
      acc_addr_reg <= '0;
      acc_data_reg <= '0;
      acc_be_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      acc_addr_reg <= acc_addr_next;
      acc_data_reg <= acc_data_next;
      acc_be_reg   <= acc_be_next;
    end
  end

  // Next accumulator state and push decision. Every case issues at most one push.
  always_comb begin
    state_next      = state_reg;
    acc_addr_next   = acc_addr_reg;
    acc_data_next   = acc_data_reg;
    acc_be_next     = acc_be_reg;
    push            = 1'b0;
    push_entry      = '0;
    if (accept) begin
      if (cur_partial && (acc_addr_reg != word_addr)) begin
        // New word address: retire the old partial word and start over with this byte.
        push            = 1'b1;
        push_entry.addr = acc_addr_reg;
        push_entry.data = acc_data_reg;
        push_entry.be   = acc_be_reg;
        state_next      = ACC_PARTIAL;
        acc_addr_next   = word_addr;
        acc_data_next   = fresh_data;
        acc_be_next     = lane_hit;
      end else if (last_lane) begin
        push            = 1'b1;
        push_entry.addr = word_addr;
        push_entry.data = merged_data;
        push_entry.be   = merged_be;
        state_next      = ACC_EMPTY;
        acc_addr_next   = '0;
        acc_data_next   = '0;
        acc_be_next     = '0;
      end else begin
        state_next      = ACC_PARTIAL;
        acc_addr_next   = word_addr;
        acc_data_next   = merged_data;
        acc_be_next     = merged_be;
      end
    end else if (dl_fall && (state_reg == ACC_PARTIAL)) begin
      // End of download: flush the partial word.
      push            = 1'b1;
      push_entry.addr = acc_addr_reg;
      push_entry.data = acc_data_reg;
      push_entry.be   = acc_be_reg;
      state_next      = ACC_EMPTY;
      acc_addr_next   = '0;
      acc_data_next   = '0;
      acc_be_next     = '0;
    end else if (dl_rise) begin
      state_next      = ACC_EMPTY;
      acc_addr_next   = '0;
      acc_data_next   = '0;
      acc_be_next     = '0;
    end
  end

  assign pop     = mem_ack && !fifo_empty;
  assign push_ok = push && (!fifo_full || pop);

  ioctl_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (push_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  assign head_entry = word_entry_t'(fifo_head);

  // Track download edges, the overflow flag, the pushed-word count and the pending completion.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      dl_prev_reg      <= 1'b0;
      overflow_reg     <= 1'b0;
      word_count_reg   <= '0;
      done_pending_reg <= 1'b0;
    end else begin
      dl_prev_reg <= ioctl_download;
      if (dl_rise)      word_count_reg <= push_ok ? AW'(1) : '0;
      else if (push_ok) word_count_reg <= word_count_reg + AW'(1);
      if (push && !push_ok) overflow_reg <= 1'b1;
      else if (dl_rise)     overflow_reg <= 1'b0;
      if (done)         done_pending_reg <= 1'b0;
      else if (dl_fall) done_pending_reg <= 1'b1;
    end
  end

  // Drive the outputs. The head is gated to zero while the FIFO is empty, so stale
  // RAM contents never appear on the port.
  always_comb begin
    mem_req    = !fifo_empty;
    mem_addr   = fifo_empty ? '0 : head_entry.addr;
    mem_din    = fifo_empty ? '0 : head_entry.data;
    mem_be     = fifo_empty ? '0 : head_entry.be;
    busy       = ioctl_download || (state_reg == ACC_PARTIAL) || !fifo_empty;
    done       = done_pending_reg && !ioctl_download &&
                 (state_reg == ACC_EMPTY) && fifo_empty;
    overflow   = overflow_reg;
    word_count = word_count_reg;
  end

endmodule

// File: doc/ioctl_wide_writer.md
Name: ioctl_wide_writer

Overview:
Parametrised successor stage for the ioctl download path. It packs the byte stream (ioctl_wr/ioctl_addr/ioctl_dout) into DW-bit words with byte enables and buffers them in a DEPTH-entry FIFO. It drains the FIFO to a memory port over a req/ack handshake, flushes partial words at end of download, and reports overflow and completion. It sits in clk_sys between the data_io outputs and SDRAM/BRAM controllers.

Parameters:
DW, 16, memory word width in bits; legal values 8, 16, 32.
AW, 24, memory word-address width.
DEPTH, 16, FIFO entries; power of two, at least 2.
BIG_ENDIAN, 0, 1: byte lane 0 maps to the MSB byte of the word.
INDEX_MASK, 8'h00, bits of ioctl_index that are compared.
INDEX_MATCH, 8'h00, required value of (ioctl_index & INDEX_MASK).

Ports:
clk_sys  in  1  system clock
reset_n  in  1  synchronous active-low reset
ioctl_download  in  1  download active
ioctl_index  in  8  menu/file index
ioctl_wr  in  1  byte strobe, one cycle
ioctl_addr  in  25  byte address
ioctl_dout  in  8  byte data
mem_req  out  1  FIFO head valid
mem_ack  in  1  head consumed, one-cycle pulse
mem_addr  out  AW  word address = ioctl_addr >> log2(DW/8)
mem_din  out  DW  word data
mem_be  out  DW/8  byte enables
busy  out  1  download active, partial word pending, or FIFO non-empty
overflow  out  1  sticky: a word was dropped
done  out  1  one-cycle completion pulse
word_count  out  AW  words pushed since download start

Behaviour:
- Interface: one clock, clk_sys. reset_n is synchronous and active-low.
- Reset (reset_n=0 at a clk_sys edge): FIFO emptied, partial accumulator cleared. All outputs are 0 from the next cycle. Reset mid-transfer discards pending data and issues no done pulse.
- Selection: a byte is accepted only when ioctl_wr=1, ioctl_download=1 and (ioctl_index & INDEX_MASK)==INDEX_MATCH.
- Start: a rising edge of ioctl_download clears overflow and word_count and discards any stale partial word.
- Lane: L = ioctl_addr[log2(DW/8)-1:0], or 0 when DW=8. An accepted byte writes lane L and sets be[L].
- Accumulator states: EMPTY and PARTIAL(word address W).
  - EMPTY + accepted byte: go to PARTIAL with W = ioctl_addr word address.
  - PARTIAL + accepted byte with the same W: merge into the word. If this fills lane DW/8-1, push the word and go to EMPTY.
  - PARTIAL + accepted byte with a different W: push the old partial word with its be, then start a new word with the incoming byte. This is one push only, with no stall.
  - PARTIAL + falling edge of ioctl_download: push the partial word (flush) and go to EMPTY.
  - A last-lane byte and a falling edge in the same cycle produce a single push.
- DW=8: every accepted byte is pushed directly with be=1.
- Push-to-output latency: data pushed into an empty FIFO appears on mem_req/mem_addr/mem_din/mem_be on the next clock edge.
- Handshake:
  - mem_req stays high while the FIFO is non-empty. Head outputs are stable while mem_req=1 and mem_ack=0.
  - mem_ack while mem_req=1 pops the head. The next entry, if any, is presented in the following cycle.
  - mem_ack while mem_req=0 is ignored.
- Full:
  - A push with the FIFO full and no simultaneous pop is dropped and sets overflow. word_count does not increment.
  - Push and pop in the same cycle while full are both accepted.
- word_count increments by 1 per accepted push and wraps modulo 2^AW.
- done: one-cycle pulse on the first cycle in which ioctl_download=0, the accumulator is EMPTY, the FIFO is empty, and a download has completed since the last done or reset.
- busy is combinational from internal state and has no pipeline delay.

Decomposition:
- Shared package ioctl_pkg holds:
  - LANES = DW/8 and LANE_W = clog2(LANES), with LANE_W forced to 0 when LANES=1;
  - the FIFO entry record {addr[AW], data[DW], be[LANES]};
  - entry width constant FW = AW+DW+LANES.
- Sub-module: ioctl_fifo, a synchronous FIFO with width FW and depth DEPTH.
  - Ports: push, pop, full, empty, head.
  - Pointers are log2(DEPTH)+1 bits wide.
  - Push and pop are allowed in the same cycle when full.

Test Plan:
- DW=16, LE: bytes 0x11@0, 0x22@1 -> one push, mem_addr=0, mem_din=16'h2211, mem_be=2'b11, word_count=1.
- DW=32, BIG_ENDIAN=1: bytes 0xAA@4, 0xBB@5, then ioctl_download falls -> flush mem_addr=1, mem_din=32'hAABB0000, mem_be=4'b1100; done pulses once after the ack.
- DW=16: bytes @0, then @6 -> push addr 0 be=2'b01; @6 stays partial (addr 3 be=2'b01) until the next event.
- DEPTH=4, mem_ack held 0, 6 full words -> 4 held in FIFO, overflow=1, word_count=4. Next download start -> overflow=0.
- INDEX_MASK=8'h3F, INDEX_MATCH=8'h02, ioctl_index=8'h41 -> no pushes, busy tracks download only, done after it falls.
- Reset with 3 entries queued and mem_req=1 -> next cycle mem_req=0, busy=0, word_count=0, no done pulse.
